// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the D-stage hazard controller.
package hazard_pkg;

  localparam logic [2:0] TUSE_NEVER    = '1;
  localparam int         MULT_LAT_DEF  = 5;
  localparam int         DIV_LAT_DEF   = 10;

  typedef enum logic {
    MDU_MULT = 1'b0,
    MDU_DIV  = 1'b1
  } mdu_class_e;

  // Forward-select width: values 0 (register file) .. nstg (oldest stage).
  function automatic int sel_width(input int nstg);
    return (nstg < 1) ? 1 : $clog2(nstg + 1);
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Down-counter that keeps the mult/div unit busy for a loaded number of cycles.
module md_busy_timer #(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [LW-1:0] load_val,
  output logic          busy
);

  logic [LW-1:0] cnt_reg;
  logic [LW-1:0] cnt_next;

  // A start while still busy simply reloads, restarting the operation.
  always_comb begin
    cnt_next = cnt_reg;
    if (start)
      cnt_next = load_val;
    else if (cnt_reg != '0)
      cnt_next = cnt_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign busy = (cnt_reg != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// D-stage stall/forward controller: register hazards against NSTG producers,
// MDU busy interlock and a saturating stall-cycle counter.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int NSTG     = 3,
  parameter int AW       = 5,
  parameter int TW       = 3,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [AW-1:0]                D_rs,
  input  logic [AW-1:0]                D_rt,
  input  logic [TW-1:0]                rs_tuse,
  input  logic [TW-1:0]                rt_tuse,
  input  logic                         D_md_use,
  input  logic [NSTG-1:0]              P_valid,
  input  logic [NSTG*AW-1:0]           P_A3,
  input  logic [NSTG*TW-1:0]           P_tnew,
  input  logic                         E_md_start,
  input  logic                         E_md_div,
  input  logic                         perf_clr,
  output logic                         stall,
  output logic                         IFU_en,
  output logic                         F2D_en,
  output logic                         D2E_en,
  output logic                         D2E_flush,
  output logic                         E2M_en,
  output logic                         M2W_en,
  output logic [sel_width(NSTG)-1:0]   fwd_rs_sel,
  output logic [sel_width(NSTG)-1:0]   fwd_rt_sel,
  output logic                         md_busy,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int SW      = sel_width(NSTG);
  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int LW      = $clog2(MAX_LAT + 1);

  logic [NSTG-1:0] rs_match, rt_match;
  logic [NSTG-1:0] rs_hit, rt_hit;
  logic [NSTG-1:0] rs_ready, rt_ready;

  for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
    logic [AW-1:0] a3;
    logic [TW-1:0] tnew;
    assign a3   = P_A3[gi*AW +: AW];
    assign tnew = P_tnew[gi*TW +: TW];

    // Register 0 is hard-wired zero: it never creates a dependency.
    assign rs_match[gi] = P_valid[gi] && (D_rs != '0) && (a3 == D_rs);
    assign rt_match[gi] = P_valid[gi] && (D_rt != '0) && (a3 == D_rt);
    assign rs_hit[gi]   = rs_match[gi] && (rs_tuse < tnew);
    assign rt_hit[gi]   = rt_match[gi] && (rt_tuse < tnew);
    assign rs_ready[gi] = rs_match[gi] && (tnew == '0);
    assign rt_ready[gi] = rt_match[gi] && (tnew == '0);
  end

  // Youngest matching stage decides; if its value is not ready yet, the
  // older copies are stale, so fall back to the register file.
  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    for (int i = NSTG - 1; i >= 0; i--) begin
      if (rs_match[i]) fwd_rs_sel = rs_ready[i] ? SW'(i + 1) : '0;
      if (rt_match[i]) fwd_rt_sel = rt_ready[i] ? SW'(i + 1) : '0;
    end
  end

  mdu_class_e    md_class;
  logic [LW-1:0] md_load;
  logic          reg_stall;
  logic          md_stall;

  assign md_class = mdu_class_e'(E_md_div);
  assign md_load  = (md_class == MDU_DIV) ? LW'(DIV_LAT) : LW'(MULT_LAT);

  md_busy_timer #(.LW(LW)) u_md_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (E_md_start),
    .load_val (md_load),
    .busy     (md_busy)
  );

  assign reg_stall = |{rs_hit, rt_hit};
  assign md_stall  = D_md_use && (md_busy || E_md_start);
  assign stall     = reg_stall | md_stall;

  assign IFU_en    = ~stall;
  assign F2D_en    = ~stall;
  assign D2E_en    = ~stall;
  assign D2E_flush = stall;
  assign E2M_en    = 1'b1;
  assign M2W_en    = 1'b1;

  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_next;

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (perf_clr)
      stall_cnt_next = '0;
    else if (stall && (stall_cnt_reg != '1))
      stall_cnt_next = stall_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt_reg <= '0;
    else
      stall_cnt_reg <= stall_cnt_next;
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with default parameters.
module tb_hazard_stall_ctrl;
  import hazard_pkg::*;

  localparam int NSTG = 3;
  localparam int AW   = 5;
  localparam int TW   = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [AW-1:0]     D_rs, D_rt;
  logic [TW-1:0]     rs_tuse, rt_tuse;
  logic              D_md_use;
  logic [NSTG-1:0]   P_valid;
  logic [NSTG*AW-1:0] P_A3;
  logic [NSTG*TW-1:0] P_tnew;
  logic              E_md_start, E_md_div, perf_clr;
  logic              stall, IFU_en, F2D_en, D2E_en, D2E_flush, E2M_en, M2W_en;
  logic [1:0]        fwd_rs_sel, fwd_rt_sel;
  logic              md_busy;
  logic [31:0]       stall_cnt;

  int n_pass = 0;
  int n_total = 0;

  hazard_stall_ctrl dut (
    .clk(clk), .reset_n(reset_n), .D_rs(D_rs), .D_rt(D_rt),
    .rs_tuse(rs_tuse), .rt_tuse(rt_tuse), .D_md_use(D_md_use),
    .P_valid(P_valid), .P_A3(P_A3), .P_tnew(P_tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div), .perf_clr(perf_clr),
    .stall(stall), .IFU_en(IFU_en), .F2D_en(F2D_en), .D2E_en(D2E_en),
    .D2E_flush(D2E_flush), .E2M_en(E2M_en), .M2W_en(M2W_en),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input int s, input logic v, input logic [AW-1:0] a3, input logic [TW-1:0] tn);
    P_valid[s]          = v;
    P_A3[s*AW +: AW]    = a3;
    P_tnew[s*TW +: TW]  = tn;
  endtask

  task automatic clr_p;
    P_valid = '0;
    P_A3    = '0;
    P_tnew  = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    D_rs = '0; D_rt = '0; rs_tuse = TUSE_NEVER; rt_tuse = TUSE_NEVER;
    D_md_use = 1'b0; E_md_start = 1'b0; E_md_div = 1'b0; perf_clr = 1'b0;
    clr_p();
    #1;
    chk("rst_md_busy", md_busy, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_stall", stall, 0);
    chk("rst_e2m_en", E2M_en, 1);
    chk("rst_m2w_en", M2W_en, 1);
    #2 reset_n = 1'b1;
    tick();

    // Load in E (tnew=2), consumer needs rs in 1 cycle.
    set_p(0, 1, 8, 2);
    D_rs = 8; rs_tuse = 1; D_rt = 0;
    #1;
    chk("lwE_stall", stall, 1);
    chk("lwE_flush", D2E_flush, 1);
    chk("lwE_ifu_en", IFU_en, 0);
    chk("lwE_f2d_en", F2D_en, 0);
    chk("lwE_d2e_en", D2E_en, 0);
    chk("lwE_fwd_rs", fwd_rs_sel, 0);
    tick();
    chk("cnt_after_1", stall_cnt, 1);

    // Load now in M (tnew=1), branch-like consumer needs rs immediately.
    clr_p();
    set_p(1, 1, 8, 1);
    rs_tuse = 0;
    #1;
    chk("lwM_tuse0_stall", stall, 1);
    tick();
    chk("cnt_after_2", stall_cnt, 2);

    // tuse == tnew is not a hazard; M still masks (value not ready).
    rs_tuse = 1;
    #1;
    chk("lwM_tuse1_stall", stall, 0);
    chk("lwM_tuse1_fwd", fwd_rs_sel, 0);

    // E and M both ready: E is the younger, so it wins.
    set_p(0, 1, 8, 0);
    set_p(1, 1, 8, 0);
    rs_tuse = 0; D_rt = 8; rt_tuse = 0;
    #1;
    chk("fwd_E_wins_stall", stall, 0);
    chk("fwd_E_wins_rs", fwd_rs_sel, 1);
    chk("fwd_E_wins_rt", fwd_rt_sel, 1);
    set_p(0, 0, 8, 0);
    #1;
    chk("fwd_M_rs", fwd_rs_sel, 2);
    // Younger E not ready masks ready M; tuse=2 tolerates tnew=1.
    set_p(0, 1, 8, 1);
    set_p(2, 1, 9, 0);
    rs_tuse = 2; D_rt = 9;
    #1;
    chk("mask_rs_sel", fwd_rs_sel, 0);
    chk("mask_stall", stall, 0);
    chk("fwd_W_rt", fwd_rt_sel, 3);
    tick();
    chk("cnt_hold_2", stall_cnt, 2);

    // Register 0 and invalid stages never match.
    clr_p();
    set_p(0, 1, 0, 2);
    D_rs = 0; rs_tuse = 0; D_rt = 0; rt_tuse = 0;
    #1;
    chk("r0_stall", stall, 0);
    chk("r0_fwd", fwd_rs_sel, 0);
    set_p(0, 0, 8, 2);
    D_rs = 8;
    #1;
    chk("invalid_stall", stall, 0);
    chk("invalid_fwd", fwd_rs_sel, 0);

    // perf_clr beats the increment while stalled.
    set_p(0, 1, 8, 2);
    perf_clr = 1'b1;
    #1;
    chk("clr_stall", stall, 1);
    tick();
    chk("clr_cnt", stall_cnt, 0);
    perf_clr = 1'b0;
    clr_p();
    tick();

    // Divide: start cycle + 10 busy cycles of stall for an HI/LO user.
    E_md_start = 1'b1; E_md_div = 1'b1; D_md_use = 1'b1;
    #1;
    chk("div_start_stall", stall, 1);
    chk("div_start_busy", md_busy, 0);
    tick();
    E_md_start = 1'b0; E_md_div = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("div_busy_%0d", k), md_busy, 1);
      chk($sformatf("div_stall_%0d", k), stall, 1);
      tick();
    end
    chk("div_done_busy", md_busy, 0);
    chk("div_done_stall", stall, 0);
    chk("div_stall_cnt", stall_cnt, 11);
    D_md_use = 1'b0;

    // Multiply without a consumer: 5 busy cycles, no stall counted.
    E_md_start = 1'b1;
    tick();
    E_md_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("mult_busy_%0d", k), md_busy, 1);
      tick();
    end
    chk("mult_done_busy", md_busy, 0);
    chk("mult_cnt_hold", stall_cnt, 11);

    // Reset in busy cycle 2 of a multiply abandons it.
    E_md_start = 1'b1; D_md_use = 1'b1;
    tick();
    E_md_start = 1'b0;
    chk("mult2_busy_1", md_busy, 1);
    tick();
    chk("mult2_busy_2", md_busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", md_busy, 0);
    chk("rst_mid_cnt", stall_cnt, 0);
    chk("rst_mid_stall", stall, 0);
    E_md_start = 1'b1;
    #1;
    chk("rst_start_stall", stall, 1);
    E_md_start = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    chk("post_rst_busy", md_busy, 0);
    chk("post_rst_stall", stall, 0);
    chk("post_rst_cnt", stall_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
